// File: rtl/mux_2to1_reg.sv
// mux_2to1_reg: registered 2-to-1 operand selector with enable and a flopped copy of the select.
module mux_2to1_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             out_sel
);
    logic [WIDTH-1:0] out_d, out_q;
    logic             out_sel_d, out_sel_q;

    if (WIDTH < 1) begin : g_bad_width
        $error("mux_2to1_reg: WIDTH must be at least 1");
    end

    always_comb begin
        out_d     = en ? (sel ? in1 : in0) : out_q;
        out_sel_d = en ? sel : out_sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= RESET_VAL;
            out_sel_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_sel_q <= out_sel_d;
        end
    end

    assign out     = out_q;
    assign out_sel = out_sel_q;
endmodule

// File: tb/tb_mux_2to1_reg.sv
// tb_mux_2to1_reg: directed test of mux_2to1_reg with hand-computed expectations.
module tb_mux_2to1_reg;
    logic       clk = 1'b0;
    logic       rst_n, en, sel;
    logic [7:0] in0, in1, out;
    logic       out_sel;
    int         n_chk = 0;
    int         n_fail = 0;

    mux_2to1_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
        .in0(in0), .in1(in1), .out(out), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] eo, input logic es);
        n_chk++;
        assert (out === eo) else begin
            n_fail++;
            $error("FAIL %s: out=%h expected %h", tag, out, eo);
        end
        n_chk++;
        assert (out_sel === es) else begin
            n_fail++;
            $error("FAIL %s: out_sel=%b expected %b", tag, out_sel, es);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; sel = 1'b0; in0 = 8'h02; in1 = 8'h01;
        #1 chk("reset_initial", 8'h00, 1'b0);
        edge_sample(); chk("reset_edge1", 8'h00, 1'b0);
        edge_sample(); chk("reset_edge2", 8'h00, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        edge_sample(); chk("release_first_capture", 8'h02, 1'b0);
        edge_sample(); chk("select_in0", 8'h02, 1'b0);
        @(negedge clk) sel = 1'b1;
        #1 chk("no_comb_path", 8'h02, 1'b0);
        edge_sample(); chk("select_in1", 8'h01, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) sel = ~sel;
            #1 chk("toggle_pre_edge", sel ? 8'h02 : 8'h01, ~sel);
            edge_sample(); chk("toggle_post_edge", sel ? 8'h01 : 8'h02, sel);
        end
        @(negedge clk) begin en = 1'b0; sel = 1'b0; in1 = 8'hFF; end
        for (int i = 0; i < 3; i++) begin
            edge_sample(); chk("hold", 8'h01, 1'b1);
        end
        @(negedge clk) en = 1'b1;
        edge_sample(); chk("hold_release", 8'h02, 1'b0);
        @(negedge clk) begin in0 = 8'hFF; in1 = 8'h80; sel = 1'b0; end
        edge_sample(); chk("all_ones_in0", 8'hFF, 1'b0);
        @(negedge clk) sel = 1'b1;
        edge_sample(); chk("msb_in1", 8'h80, 1'b1);
        @(negedge clk) begin in0 = 8'hA5; in1 = 8'hA5; sel = 1'b0; end
        edge_sample(); chk("equal_sel0", 8'hA5, 1'b0);
        @(negedge clk) sel = 1'b1;
        edge_sample(); chk("equal_sel1", 8'hA5, 1'b1);
        @(negedge clk) begin in0 = 8'h02; in1 = 8'h01; sel = 1'b1; end
        edge_sample(); chk("pre_async_reset", 8'h01, 1'b1);
        @(negedge clk) #2 rst_n = 1'b0;
        #1 chk("async_reset_immediate", 8'h00, 1'b0);
        edge_sample(); chk("reset_hold_edge1", 8'h00, 1'b0);
        edge_sample(); chk("reset_hold_edge2", 8'h00, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        edge_sample(); chk("post_reset_capture", 8'h01, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_2to1_reg.md
Name: mux_2to1_reg

Overview:
- Registered 2-to-1 data selector: picks one of two WIDTH-bit operands by a 1-bit select and presents it on a flopped output.
- Sits in the datapath wherever an operand source must be chosen per cycle (e.g. ALU operand or writeback source).
- Output is timing-clean: a single register stage, no combinational path from inputs to `out`.

Parameters:
- WIDTH, 8, data width of in0, in1 and out.
- RESET_VAL, 0 (WIDTH bits), value loaded into `out` on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  capture enable. 1 = update on clock edge; 0 = hold. Tie high when unused.
- sel  input  1  select. 0 = in0, 1 = in1.
- in0  input  WIDTH  operand 0.
- in1  input  WIDTH  operand 1.
- out  output  WIDTH  registered selected operand.
- out_sel  output  1  registered copy of the sel value that produced the current `out`.

Behaviour:
- Reset:
  - rst_n low forces out=RESET_VAL and out_sel=0 immediately, independent of clk.
  - Values are held while rst_n is low.
  - Release is synchronous in effect: the first capture occurs on the first rising edge with rst_n high.
- Capture, on each rising clk edge with rst_n=1 and en=1:
  - out <= (sel ? in1 : in0)
  - out_sel <= sel
- Hold: en=0 leaves out and out_sel unchanged regardless of sel, in0 or in1.
- Latency: exactly 1 cycle from input/select sampled at an edge to `out` valid after that edge. No combinational path from any input to `out`.
- Sel change: takes effect at the next capturing edge. There are no glitches on `out` between edges.
- Identical operands (in0==in1): `out` equals that value for either sel. out_sel still tracks sel.
- X/Z on sel is not a legal operating condition. The bench must keep sel driven to 0 or 1 whenever en=1.
- Width rules:
  - Pure selection; no arithmetic, extension or truncation.
  - All data ports are exactly WIDTH bits.
  - Every bit is passed unmodified, including MSB and all-ones patterns.
- Reset mid-operation: asserting rst_n between edges overrides any pending capture. The following edges are ignored until release.
- Simultaneous events: if rst_n deasserts coincident with a clk edge, that edge does not capture. Capture begins on the next edge.
- Implementation guidance:
  - One always block, sensitive to posedge clk / negedge rst_n, for out and out_sel.
  - Parameter checks: WIDTH >= 1, RESET_VAL fits WIDTH.
  - Optional simulation-only assertion flags sel=X while en=1.

Test Plan:
- Reset: rst_n=0 with in0=8'h02, in1=8'h01, sel=0, clk toggling -> out=8'h00, out_sel=0 throughout. Release rst_n -> first edge after release gives out=8'h02.
- Select in0: en=1, in0=8'h02, in1=8'h01, sel=0, one edge (clk period 10 units) -> out=8'h02, out_sel=0. `out` does not change before the edge.
- Select in1: same operands, sel=1 at the next half-period, next edge -> out=8'h01, out_sel=1. Toggle sel every cycle for 8 cycles -> out alternates 02/01 with 1-cycle lag.
- Hold: out=8'h01, then en=0, sel=0, in1=8'hFF for 3 edges -> out stays 8'h01, out_sel stays 1. Set en=1 -> next edge out=8'h02.
- Boundary data: in0=8'hFF, in1=8'h80 then in0=in1=8'hA5 across both sel values -> out exactly FF/80, then A5 for both sel. out_sel still follows sel.
- Async reset mid-run: mid-cycle rst_n=0 while out=8'h01 -> out=8'h00 immediately, before the next edge. Hold reset for 2 edges -> no capture.
